// File: rtl/mem_port_arbiter_if.sv
// Bundle of the loader, CPU and RAM-side signals of the memory port arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Serial loader write stream
  logic [11:0]      ld_addr;
  logic [17:0]      ld_data;
  logic             ld_we;
  logic             ld_busy;
  logic             ld_overflow;
  logic [LVL_W-1:0] fifo_level;

  // CPU memory interface
  logic             cpu_req;
  logic             cpu_we;
  logic [11:0]      cpu_addr;
  logic [17:0]      cpu_wdata;
  logic             cpu_ack;
  logic [17:0]      cpu_rdata;

  // Main RAM port
  logic             mem_en;
  logic             mem_we;
  logic [11:0]      mem_addr;
  logic [17:0]      mem_wdata;
  logic [17:0]      mem_rdata;

  modport slave (
    input  ld_addr, ld_data, ld_we,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output ld_busy, ld_overflow, fifo_level,
    output cpu_ack, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ld_addr, ld_data, ld_we,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  ld_busy, ld_overflow, fifo_level,
    input  cpu_ack, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port 4096 x 18 main RAM between the CPU (req/ack) and the
// serial program loader (write-only strobes, buffered in a small FIFO).
// A starvation counter forces a loader write after MAX_WAIT CPU wins.
module mem_port_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave arb
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(MAX_WAIT + 1);
  localparam int ENT_W = 30;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    C_ISSUE = 3'd1,
    C_DATA  = 3'd2,
    C_ACK   = 3'd3,
    L_WRITE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Registered RAM port and CPU response
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [11:0]      mem_addr_q, mem_addr_d;
  logic [17:0]      mem_wdata_q, mem_wdata_d;
  logic             cpu_ack_q, cpu_ack_d;
  logic [17:0]      cpu_rdata_q, cpu_rdata_d;
  logic             cpu_we_q, cpu_we_d;
  logic [STV_W-1:0] starve_q, starve_d;

  // Loader FIFO
  logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;

  logic             fifo_empty;
  logic             fifo_full;
  logic             starve_sat;
  logic             pop;
  logic             push_ok;
  logic [ENT_W-1:0] fifo_head;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign starve_sat = (starve_q >= STV_W'(MAX_WAIT));
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = arb.ld_we && (!fifo_full || pop);

  // Arbitration and access sequencing; pop is issued only from IDLE.
  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_we_d    = cpu_we_q;
    starve_d    = starve_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (!fifo_empty && (!arb.cpu_req || starve_sat)) begin
          pop         = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = fifo_head[29:18];
          mem_wdata_d = fifo_head[17:0];
          starve_d    = '0;
          state_d     = L_WRITE;
        end else if (arb.cpu_req) begin
          mem_en_d    = 1'b1;
          mem_we_d    = arb.cpu_we;
          mem_addr_d  = arb.cpu_addr;
          mem_wdata_d = arb.cpu_wdata;
          cpu_we_d    = arb.cpu_we;
          // Only CPU wins over a waiting loader count towards starvation.
          if (fifo_empty) begin
            starve_d = '0;
          end else if (!starve_sat) begin
            starve_d = starve_q + STV_W'(1);
          end
          state_d     = C_ISSUE;
        end
      end
      C_ISSUE: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = C_DATA;
      end
      C_DATA: begin
        // RAM read data is valid now; writes leave the last read value in place.
        if (!cpu_we_q) begin
          cpu_rdata_d = arb.mem_rdata;
        end
        cpu_ack_d = 1'b1;
        state_d   = C_ACK;
      end
      C_ACK: begin
        // cpu_req is ignored here; a held request is re-arbitrated in IDLE.
        state_d = IDLE;
      end
      L_WRITE: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // FSM state, RAM port and CPU response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_we_q    <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_we_q    <= cpu_we_d;
      starve_q    <= starve_d;
    end
  end

  // FIFO pointer, occupancy and sticky-overflow next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_ok && pop) begin
      level_d = level_q - LVL_W'(1);
    end
    if (arb.ld_we && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO control registers; reset discards any queued loader words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage: {addr, data} per entry, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= {arb.ld_addr, arb.ld_data};
    end
  end

  assign arb.mem_en      = mem_en_q;
  assign arb.mem_we      = mem_we_q;
  assign arb.mem_addr    = mem_addr_q;
  assign arb.mem_wdata   = mem_wdata_q;
  assign arb.cpu_ack     = cpu_ack_q;
  assign arb.cpu_rdata   = cpu_rdata_q;
  assign arb.fifo_level  = level_q;
  assign arb.ld_overflow = ovf_q;
  assign arb.ld_busy     = !fifo_empty || (state_q == L_WRITE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level reference model
// predicts RAM grants and CPU acks with their timestamps; a negedge monitor
// pops and compares whenever the DUT presents them.
module tb_mem_port_arbiter;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_WAIT   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  mem_port_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Initial RAM image: address in the low bits, 60 octal above.
  function automatic logic [17:0] init_word(input logic [11:0] a);
    return {6'o60, a};
  endfunction

  // Behavioural RAM with registered read.
  bit [17:0] ram    [4096];
  bit        ram_wr [4096];
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr]    <= bus.mem_wdata;
        ram_wr[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : init_word(bus.mem_addr);
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          stamp;
    bit          we;
    logic [11:0] addr;
    logic [17:0] data;
  } ev_t;

  ev_t         exp_mem [$];
  ev_t         exp_ack [$];
  logic [29:0] lq [$];
  bit   [17:0] refmem [4096];
  bit          ref_wr [4096];
  int          edge_cnt    = 0;
  int          next_decide = 0;
  int          starve      = 0;
  int          lw_edge     = -1;
  bit          ovf         = 1'b0;
  bit          rst_at_edge = 1'b0;
  logic [17:0] hold_rdata  = '0;

  function automatic logic [17:0] ref_rd(input logic [11:0] a);
    return ref_wr[a] ? refmem[a] : init_word(a);
  endfunction

  // Port arbitration at transaction level: decision edges are computed from
  // access durations (loader 2 cycles, CPU 4 cycles).
  always @(posedge clk) begin : model
    logic [29:0] w;
    ev_t         e;
    edge_cnt++;
    rst_at_edge = rst;
    if (rst) begin
      lq.delete();
      exp_mem.delete();
      exp_ack.delete();
      starve      = 0;
      ovf         = 1'b0;
      lw_edge     = -1;
      next_decide = edge_cnt + 1;
    end else begin
      if (edge_cnt == next_decide) begin
        if (lq.size() != 0 && (!bus.cpu_req || starve >= MAX_WAIT)) begin
          w = lq.pop_front();
          e.stamp = edge_cnt; e.we = 1'b1; e.addr = w[29:18]; e.data = w[17:0];
          exp_mem.push_back(e);
          refmem[w[29:18]] = w[17:0];
          ref_wr[w[29:18]] = 1'b1;
          starve      = 0;
          lw_edge     = edge_cnt;
          next_decide = edge_cnt + 2;
        end else if (bus.cpu_req) begin
          e.stamp = edge_cnt; e.we = bus.cpu_we; e.addr = bus.cpu_addr; e.data = bus.cpu_wdata;
          exp_mem.push_back(e);
          if (bus.cpu_we) begin
            refmem[bus.cpu_addr] = bus.cpu_wdata;
            ref_wr[bus.cpu_addr] = 1'b1;
          end else begin
            e.data = ref_rd(bus.cpu_addr);
          end
          e.stamp = edge_cnt + 2;
          exp_ack.push_back(e);
          if (lq.size() == 0) starve = 0;
          else if (starve < MAX_WAIT) starve++;
          next_decide = edge_cnt + 4;
        end else begin
          next_decide = edge_cnt + 1;
        end
      end
      if (bus.ld_we) begin
        if (lq.size() < FIFO_DEPTH) lq.push_back({bus.ld_addr, bus.ld_data});
        else ovf = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_cnt, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    bit  exp_en;
    bit  exp_ak;
    ev_t ev;
    if (edge_cnt > 0) begin
      if (rst_at_edge) hold_rdata = '0;
      exp_en = (exp_mem.size() != 0) && (exp_mem[0].stamp == edge_cnt);
      chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
      if (exp_en) begin
        ev = exp_mem.pop_front();
        chk("mem_we", 32'(bus.mem_we), 32'(ev.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ev.addr));
        if (ev.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(ev.data));
      end
      exp_ak = (exp_ack.size() != 0) && (exp_ack[0].stamp == edge_cnt);
      chk("cpu_ack", 32'(bus.cpu_ack), 32'(exp_ak));
      if (exp_ak) begin
        ev = exp_ack.pop_front();
        if (!ev.we) hold_rdata = ev.data;
      end
      chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(hold_rdata));
      chk("fifo_level", 32'(bus.fifo_level), 32'(lq.size()));
      chk("ld_overflow", 32'(bus.ld_overflow), 32'(ovf));
      chk("ld_busy", 32'(bus.ld_busy), 32'((lq.size() != 0) || (lw_edge == edge_cnt)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ld_push(input logic [11:0] a, input logic [17:0] d);
    bus.ld_we   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    @(posedge clk); #1;
    bus.ld_we   = 1'b0;
  endtask

  // Issues one CPU access and waits for its ack; keep=1 leaves cpu_req high
  // so the next call forms a back-to-back request.
  task automatic cpu_op(input bit we, input logic [11:0] a, input logic [17:0] d, input bit keep);
    int n;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.cpu_ack !== 1'b1 && n < 200);
    chk("cpu_ack_wait", 32'(bus.cpu_ack), 32'(1));
    if (!keep) bus.cpu_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single loader word, idle CPU.
    ld_push(12'o100, 18'o123456);
    idle(6);

    // CPU read of the preloaded word at 4.
    cpu_op(1'b0, 12'o4, 18'o0, 1'b0);
    chk("t2_rdata", 32'(bus.cpu_rdata), 32'(18'o600004));
    idle(3);

    // Back-to-back CPU traffic with one queued loader word: starvation bound.
    fork
      for (int i = 0; i < 12; i++)
        cpu_op(1'($urandom), 12'($urandom_range(0, 15)), 18'($urandom), i < 11);
      begin idle(2); ld_push(12'o200, 18'o777001); end
    join
    idle(4);

    // Five consecutive loader strobes while the CPU owns the port.
    fork
      for (int i = 0; i < 6; i++)
        cpu_op(1'($urandom), 12'($urandom_range(0, 15)), 18'($urandom), i < 5);
      begin
        idle(1);
        for (int i = 0; i < 5; i++) ld_push(12'(12'o300 + i), 18'(18'o1000 + i));
      end
    join
    chk("t4_overflow", 32'(bus.ld_overflow), 32'(1));
    idle(12);

    // CPU vs queued loader word with starve=0, then loader wins when CPU idles.
    fork
      begin
        cpu_op(1'b1, 12'o10, 18'o111111, 1'b1);
        cpu_op(1'b0, 12'o10, 18'o0, 1'b0);
      end
      begin idle(1); ld_push(12'o10, 18'o222222); end
    join
    idle(8);

    // Reset in the middle of a CPU access with two loader words queued.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'o7;
    bus.ld_we = 1'b1; bus.ld_addr = 12'o400; bus.ld_data = 18'o4040;
    @(posedge clk); #1;
    bus.ld_addr = 12'o401; bus.ld_data = 18'o4141;
    @(posedge clk); #1;
    bus.ld_we = 1'b0;
    n = 0;
    while (bus.cpu_ack !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("t6_first_ack", 32'(bus.cpu_ack), 32'(1));
    n = 0;
    while (bus.mem_en !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("t6_second_grant", 32'(bus.mem_en), 32'(1));
    chk("t6_level_before", 32'(bus.fifo_level), 32'(2));
    rst = 1'b1; bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("t6_mem_en", 32'(bus.mem_en), 32'(0));
    chk("t6_mem_we", 32'(bus.mem_we), 32'(0));
    chk("t6_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("t6_mem_wdata", 32'(bus.mem_wdata), 32'(0));
    chk("t6_cpu_ack", 32'(bus.cpu_ack), 32'(0));
    chk("t6_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
    chk("t6_level", 32'(bus.fifo_level), 32'(0));
    chk("t6_overflow", 32'(bus.ld_overflow), 32'(0));
    chk("t6_busy", 32'(bus.ld_busy), 32'(0));
    rst = 1'b0;
    idle(2);

    // Randomized mixed traffic over a small address window.
    fork
      for (int i = 0; i < 50; i++) begin
        int gap;
        gap = $urandom_range(0, 3);
        cpu_op(1'($urandom), 12'($urandom_range(0, 15)), 18'($urandom), gap == 0);
        if (gap != 0) idle(gap);
      end
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 3) == 0) ld_push(12'($urandom_range(0, 15)), 18'($urandom));
        else idle(1);
      end
    join
    idle(30);

    chk("drain_mem_events", 32'(exp_mem.size()), 32'(0));
    chk("drain_ack_events", 32'(exp_ack.size()), 32'(0));
    chk("drain_fifo", 32'(bus.fifo_level), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port PDP-1 main memory (4096 x 18-bit synchronous RAM) between two requesters:
- the CPU memory interface (read/write, req/ack handshake);
- the UART program loader write stream (one-cycle we pulses, no backpressure).

Loader writes are buffered in a small FIFO and interleaved with CPU accesses. A starvation counter bounds how long loader writes can be deferred behind CPU traffic. The block sits between the CPU core, the serial loader and the main RAM instance.

Parameters:
FIFO_DEPTH, 4, loader write FIFO entries (power of 2, >=2)
MAX_WAIT, 8, CPU-won arbitration decisions tolerated while the FIFO is non-empty before the loader is forced

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ld_addr  in  12  loader write address
ld_data  in  18  loader write data
ld_we  in  1  one-cycle loader write strobe; push into FIFO
ld_busy  out  1  FIFO non-empty or loader write in progress
ld_overflow  out  1  sticky: a push was dropped because the FIFO was full
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read (sampled with cpu_req)
cpu_addr  in  12  CPU address
cpu_wdata  in  18  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  18  read data, valid while cpu_ack=1 and held afterwards
mem_en  out  1  RAM enable (registered)
mem_we  out  1  RAM write enable (registered)
mem_addr  out  12  RAM address (registered)
mem_wdata  out  18  RAM write data (registered)
mem_rdata  in  18  RAM read data, valid one cycle after mem_en

Behaviour:
- Reset values (cycle after rst=1): every output 0, FIFO empty, starve counter 0, state IDLE. A reset mid-access aborts it: no cpu_ack, queued loader writes are lost, mem_en=0.
- FIFO push: on ld_we, push {ld_addr, ld_data} if not full.
- FIFO full: push dropped and ld_overflow set. ld_overflow stays 1 until rst.
- Simultaneous push and pop: both succeed and level is unchanged. This applies when full too: the pop frees a slot and the push is accepted.
- States: IDLE, C_ISSUE, C_DATA, C_ACK, L_WRITE.
- IDLE arbitration:
  - If FIFO non-empty and (cpu_req=0 or starve>=MAX_WAIT): pop the FIFO head into mem_* with mem_en=1, mem_we=1; starve<=0; go to L_WRITE.
  - Else if cpu_req=1: latch cpu_addr/cpu_we/cpu_wdata into mem_* with mem_en=1, mem_we=cpu_we; go to C_ISSUE.
  - In the CPU branch, starve increments (saturating at MAX_WAIT) when the FIFO is non-empty, and clears to 0 when the FIFO is empty.
- L_WRITE: RAM performs the write this cycle. Next cycle: mem_en=0, mem_we=0, go to IDLE. Loader throughput is 1 word per 2 cycles.
- C_ISSUE: RAM performs the access. Next cycle: mem_en=0, go to C_DATA.
- C_DATA: mem_rdata valid. Register it into cpu_rdata (reads only; cpu_rdata unchanged on writes), set cpu_ack=1, go to C_ACK.
- C_ACK: cpu_ack=1 this cycle only; go to IDLE. cpu_req is ignored in C_ACK.
- CPU handshake rule: the CPU deasserts cpu_req, or presents a new request, in the cycle after cpu_ack. Keeping cpu_req high in IDLE starts a new access.
- CPU latency: req seen in IDLE at cycle T, mem_en=1 at T+1, cpu_ack=1 at T+3. Best-case back-to-back CPU rate is 1 access per 4 cycles.
- A CPU request arriving while in L_WRITE waits; it is served in the next IDLE unless the loader is again eligible.
- A loader write to the address the CPU is reading: ordering follows the arbitration order. No forwarding.
- ld_busy = (fifo_level!=0) | (state==L_WRITE).
- Addresses are 12 bits: no wrap or translation. Data is 18 bits, passed unmodified.

Test Plan:
1. Reset, then ld_we with addr 12'o100 data 18'o123456, no CPU traffic. Expect mem_en=mem_we=1, mem_addr=12'o100, mem_wdata=18'o123456 exactly 2 cycles after ld_we (push at T+1, IDLE grant registered at T+2). ld_busy falls after L_WRITE.
2. CPU read of 12'o4 with RAM model holding 18'o600004. Expect cpu_ack pulse 3 cycles after req with cpu_rdata=18'o600004, mem_we=0.
3. CPU holds back-to-back requests continuously while one loader word is queued. Expect the loader write to be granted after exactly MAX_WAIT=8 CPU grants. No CPU ack is lost; cpu_ack pulses every 4 cycles otherwise.
4. Five ld_we pulses on consecutive cycles while the CPU occupies the port. Expect fifo_level to reach 4 and ld_overflow=1 with the 5th word dropped. The 4 words are written in order once granted.
5. Simultaneous cpu_req and FIFO non-empty with starve=0 and cpu_req=1. Expect CPU wins. Then with cpu_req=0, the loader wins next IDLE.
6. Assert rst during C_ISSUE with 2 FIFO entries. Expect no cpu_ack, fifo_level=0, ld_overflow=0, all mem_* = 0 the next cycle, normal operation afterwards.
